wire_break_qualifier: RTL
=========================

# wire_break_qualifier

Conditions the asynchronous wire-sensor input and qualifies the wire-break event that follows each detonator firing. Sits between the wire-sensor pin and the main sequencing FSM. It is armed by the FSM's `detonator_triggered` pulse, rejects the contact bounce on the sensor, and returns a single clean `wire_event` pulse with the measured arm-to-break delay. If no qualified break arrives within a bounded window, it returns a timeout instead.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops on `wire_sensor` (≥2)
- STABLE_CYCLES, 16: consecutive identical synchronized samples required to qualify a level (≥2)
- TIMEOUT_CYCLES, 1_000_000: arm-to-break window in clk cycles (< 2^CNT_W)
- CNT_W, 24: delay counter width

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- detonator_triggered  in  1  arm request, level or pulse; the rising edge arms the block
- wire_sensor  in  1  raw asynchronous sensor; high = wire broken
- wire_event  out  1  one-cycle pulse on a qualified break
- delay_valid  out  1  high from `wire_event` until the next arm or reset
- delay_cnt  out  CNT_W  cycles from arm to the first synchronized sample of the qualifying run
- timeout  out  1  one-cycle pulse when the window expires
- glitch_cnt  out  4  rejected high runs since arm, saturates at 15
- busy  out  1  high in every state except IDLE

## Operation
- Input `wire_sensor` passes through SYNC_STAGES flops to give `ws_s`. All logic uses `ws_s` only.
- `detonator_triggered` is edge-detected with one register. Arming happens on its rising edge, so a held-high input arms only once.
- FSM states: IDLE, ARMED, QUALIFY, RELEASE.
- IDLE:
  - On an arm edge: clear the counter, `glitch_cnt` and `delay_valid`, then go to ARMED.
  - All arm edges outside IDLE are ignored.
- ARMED:
  - `cnt` increments by 1 each cycle.
  - When `ws_s`=1: latch `run_start`=`cnt`, set `stable`=1, go to QUALIFY.
- QUALIFY:
  - `cnt` keeps incrementing.
  - While `ws_s`=1, `stable` increments.
  - If `ws_s`=0 before `stable` reaches STABLE_CYCLES: `glitch_cnt`+1 (saturating), go back to ARMED.
  - When `stable`=STABLE_CYCLES: pulse `wire_event`, `delay_cnt`←`run_start`, set `delay_valid`, go to RELEASE.
- Timeout, in ARMED or QUALIFY:
  - Fires when `cnt` reaches TIMEOUT_CYCLES−1 with no qualification.
  - Response: pulse `timeout`, leave `delay_valid` low, go to IDLE.
  - If qualification and timeout happen in the same cycle, qualification wins.
- RELEASE:
  - Waits for STABLE_CYCLES consecutive `ws_s`=0 samples, then goes to IDLE.
  - Any `ws_s`=1 sample restarts this count.
  - Prevents the 1 ms sensor hold from re-triggering.
- `cnt` never wraps, because TIMEOUT_CYCLES < 2^CNT_W. All arithmetic is unsigned.

## Timing
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - Synchronizer flops, `cnt`, `stable`, `run_start` and the edge register go to 0.
  - Outputs: `wire_event`=0, `delay_valid`=0, `delay_cnt`=0, `timeout`=0, `glitch_cnt`=0, `busy`=0.
- Reset asserted mid-operation aborts at that edge. No `wire_event` or `timeout` is emitted.
- Arm latency: the FSM enters ARMED on the edge after the arm edge is seen. `busy` rises in the same cycle, and the first `cnt` value in ARMED is 0.
- Input latency: a `wire_sensor` rise that is stable from edge t appears on `ws_s` at edge t+SYNC_STAGES.
- Qualification: `wire_event` is high during the cycle after the STABLE_CYCLES-th consecutive high `ws_s` sample. Total pin-to-event latency is SYNC_STAGES+STABLE_CYCLES cycles.
- Output registering:
  - `delay_cnt` and `delay_valid` update on the same edge as `wire_event`.
  - All outputs are registered.
- Pulse width: `wire_event` and `timeout` are exactly one cycle wide, and at most one of the two fires per arm.

## Test plan
Use defaults except TIMEOUT_CYCLES=1000.
- Clean break: arm, `wire_sensor` high 200 cycles after arm → one `wire_event` at arm+200+2+16 (±1 for async sampling), `delay_cnt`≈200, `glitch_cnt`=0, no `timeout`.
- Bounce: arm, then 5 high pulses of 3–10 cycles each, then solid high → `glitch_cnt`=5, exactly one `wire_event`, `delay_cnt` equals the arrival cycle of the solid run.
- Timeout: arm with no sensor activity → `timeout` pulse when `cnt`=999, `busy` falls the next cycle, `delay_valid`=0, no `wire_event`.
- Re-arm suppression: a second `detonator_triggered` edge, or a continuous high, during ARMED/RELEASE → ignored. The sensor held high for 1 ms after the event → no second `wire_event`, and the block returns to IDLE only after 16 low samples.
- Reset mid-QUALIFY: `reset_n` low for 1 cycle at `stable`=8 → all outputs 0, IDLE, no pulse. Re-arming afterwards → normal qualification.
- Boundary: a high run of exactly 15 samples → glitch counted, no event. A run of exactly 16 → event. Qualification landing on `cnt`=999 → `wire_event`, no `timeout`.

Source files
------------

// File: rtl/wire_break_qualifier.sv
// wire_break_qualifier
//   Conditions the asynchronous wire-sensor pin and qualifies the wire-break
//   that follows a detonator firing. Armed by a rising edge on
//   detonator_triggered, it rejects contact bounce, then returns one clean
//   wire_event pulse with the arm-to-break delay, or a timeout pulse if no
//   qualified break arrives inside the window.
//
// Ports
//   clk                 system clock
//   reset_n             synchronous reset, active-low
//   detonator_triggered arm request; rising edge arms (IDLE only)
//   wire_sensor         raw asynchronous sensor, high = wire broken
//   wire_event          one-cycle pulse on a qualified break
//   delay_valid         high from wire_event until the next arm or reset
//   delay_cnt           cycles from arm to first sample of the qualifying run
//   timeout             one-cycle pulse when the window expires
//   glitch_cnt          rejected high runs since arm, saturating at 15
//   busy                high in every state except IDLE
module wire_break_qualifier #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned CNT_W          = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             detonator_triggered,
    input  logic             wire_sensor,
    output logic             wire_event,
    output logic             delay_valid,
    output logic [CNT_W-1:0] delay_cnt,
    output logic             timeout,
    output logic [3:0]       glitch_cnt,
    output logic             busy
);

    localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CntLast   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0] StableMax = STB_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {StIdle, StArmed, StQualify, StRelease} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   trig_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       run_start_q, run_start_d;
    logic [STB_W-1:0]       stable_q, stable_d;
    logic [CNT_W-1:0]       delay_cnt_q, delay_cnt_d;
    logic                   delay_valid_q, delay_valid_d;
    logic [3:0]             glitch_q, glitch_d;
    logic                   wire_event_q, timeout_q, busy_q;

    logic             ws_s;
    logic             arm_edge;
    logic [STB_W-1:0] stable_inc;
    logic             qualify, expire, release_done;

    assign ws_s       = sync_q[SYNC_STAGES-1];
    assign arm_edge   = detonator_triggered & ~trig_q;
    assign stable_inc = stable_q + STB_W'(1);

    // Qualification takes priority over an expiring window in the same cycle.
    assign qualify      = (state_q == StQualify) && ws_s && (stable_inc == StableMax);
    assign expire       = ((state_q == StArmed) || (state_q == StQualify)) &&
                          (cnt_q == CntLast) && !qualify;
    assign release_done = (state_q == StRelease) && !ws_s && (stable_inc == StableMax);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (arm_edge) state_d = StArmed;
            StArmed: begin
                if (expire)    state_d = StIdle;
                else if (ws_s) state_d = StQualify;
            end
            StQualify: begin
                if (qualify)     state_d = StRelease;
                else if (expire) state_d = StIdle;
                else if (!ws_s)  state_d = StArmed;
            end
            StRelease: if (release_done) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        cnt_d         = cnt_q;
        run_start_d   = run_start_q;
        stable_d      = stable_q;
        delay_cnt_d   = delay_cnt_q;
        delay_valid_d = delay_valid_q;
        glitch_d      = glitch_q;
        unique case (state_q)
            StIdle: begin
                if (arm_edge) begin
                    cnt_d         = '0;
                    stable_d      = '0;
                    glitch_d      = '0;
                    delay_valid_d = 1'b0;
                end
            end
            StArmed: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (ws_s) begin
                    run_start_d = cnt_q;
                    stable_d    = STB_W'(1);
                end
            end
            StQualify: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (ws_s) begin
                    stable_d = stable_inc;
                end else if (glitch_q != 4'hF) begin
                    glitch_d = glitch_q + 4'd1;
                end
                if (qualify) begin
                    delay_cnt_d   = run_start_q;
                    delay_valid_d = 1'b1;
                    stable_d      = '0;  // reused as the low-run counter in RELEASE
                end
            end
            StRelease: begin
                if (ws_s || release_done) stable_d = '0;
                else                      stable_d = stable_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q        <= '0;
            trig_q        <= 1'b0;
            cnt_q         <= '0;
            run_start_q   <= '0;
            stable_q      <= '0;
            delay_cnt_q   <= '0;
            delay_valid_q <= 1'b0;
            glitch_q      <= '0;
            wire_event_q  <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], wire_sensor};
            trig_q        <= detonator_triggered;
            cnt_q         <= cnt_d;
            run_start_q   <= run_start_d;
            stable_q      <= stable_d;
            delay_cnt_q   <= delay_cnt_d;
            delay_valid_q <= delay_valid_d;
            glitch_q      <= glitch_d;
            wire_event_q  <= qualify;
            timeout_q     <= expire;
            busy_q        <= (state_d != StIdle);
        end
    end

    assign wire_event  = wire_event_q;
    assign delay_valid = delay_valid_q;
    assign delay_cnt   = delay_cnt_q;
    assign timeout     = timeout_q;
    assign glitch_cnt  = glitch_q;
    assign busy        = busy_q;

endmodule
